// File: rtl/xpkt_pkg.sv
`default_nettype none
// ============================================================================
// Package     : xpkt_pkg
// Description : Shared types and constants for the switch-port packet reader.
//               Reader FSM state encoding, error-counter ceiling and a
//               saturating increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package xpkt_pkg;

  // Packet-reader FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } state_e;

  // Truncation counter ceiling
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // Saturating 8-bit increment
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage : xpkt_pkg
`default_nettype wire

// File: rtl/xskid2.sv
`default_nettype none
// ============================================================================
// Module      : xskid2
// Description : Generic 2-entry valid/ready skid buffer. The head entry drives
//               dout directly from a register, so outputs stay stable while
//               valid=1 and ready=0. A push into a full buffer is ignored;
//               the producer is expected to honour 'full'.
// Ports       : clk, rstn     - clock, synchronous active-low reset
//               push, din     - write strobe and data
//               full          - both entries occupied (registered)
//               valid, ready  - downstream handshake
//               dout          - head entry
// Revision    : 1.0 - initial release
// ============================================================================
module xskid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] dout
);

  logic [1:0]   cnt;
  logic [W-1:0] e0;   // head
  logic [W-1:0] e1;   // second entry
  logic         pop;

  assign valid = (cnt != 2'd0);
  assign full  = (cnt == 2'd2);
  assign pop   = valid & ready;
  assign dout  = e0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      case (cnt)
        2'd0: begin
          if (push) begin
            e0  <= din;
            cnt <= 2'd1;
          end
        end
        2'd1: begin
          // Simultaneous push/pop: new word goes straight to the head.
          if (push && pop) begin
            e0 <= din;
          end else if (push) begin
            e1  <= din;
            cnt <= 2'd2;
          end else if (pop) begin
            cnt <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            e0  <= e1;
            cnt <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule : xskid2
`default_nettype wire

// File: rtl/xff_pkt_rd.sv
`default_nettype none
// ============================================================================
// Module      : xff_pkt_rd
// Description : Packet reader for the read side of a switch-port FIFO. Pops
//               flits via ff_re/ff_empty_n, tracks packet length, truncates
//               packets longer than MAXLEN (forcing a tail and draining the
//               rest) and presents flits through a 2-entry skid buffer.
// Ports       : clk, rstn        - clock, synchronous active-low reset
//               ff_empty_n, ff_re, ff_q - FIFO strobe interface, ff_q[DW]=last
//               o_valid, o_ready - downstream handshake
//               o_data, o_last, o_len, o_trunc - flit and tail information
//               err_cnt          - saturating truncation count
// Revision    : 1.0 - initial release
// ============================================================================
module xff_pkt_rd
  import xpkt_pkg::*;
#(
  parameter int DW     = 8,
  parameter int MAXLEN = 16,
  parameter int LW     = $clog2(MAXLEN + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ff_empty_n,
  output logic          ff_re,
  input  logic [DW:0]   ff_q,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic          o_last,
  output logic [LW-1:0] o_len,
  output logic          o_trunc,
  output logic [7:0]    err_cnt
);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [LW-1:0] len;
    logic          trunc;
  } entry_t;

  localparam int            EW       = DW + LW + 2;
  localparam logic [LW-1:0] MAXLEN_L = LW'(MAXLEN);

  state_e        state, next_state;
  logic [LW-1:0] fcnt, next_fcnt, fcnt_inc;
  logic          skid_full;
  logic          push;
  logic          err_inc;
  logic          flit_last;
  entry_t        push_entry;
  entry_t        head;

  // Fullness is registered inside the skid, so o_ready never reaches ff_re.
  assign ff_re     = rstn & ff_empty_n & ((state == DROP) | ~skid_full);
  assign flit_last = ff_q[DW];
  assign fcnt_inc  = fcnt + LW'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      fcnt    <= '0;
      err_cnt <= 8'd0;
    end else begin
      state <= next_state;
      fcnt  <= next_fcnt;
      if (err_inc) begin
        err_cnt <= sat_inc8(err_cnt);
      end
    end
  end

  always_comb begin
    next_state       = state;
    next_fcnt        = fcnt;
    push             = 1'b0;
    err_inc          = 1'b0;
    push_entry.data  = ff_q[DW-1:0];
    push_entry.last  = 1'b0;
    push_entry.len   = fcnt_inc;
    push_entry.trunc = 1'b0;

    if (ff_re) begin
      case (state)
        IDLE: begin
          push = 1'b1;
          if (flit_last) begin
            push_entry.last = 1'b1;
            next_fcnt       = '0;
          end else begin
            next_state = BODY;
            next_fcnt  = fcnt_inc;
          end
        end
        BODY: begin
          push = 1'b1;
          // A natural tail on flit MAXLEN wins over truncation.
          if (flit_last) begin
            push_entry.last = 1'b1;
            next_fcnt       = '0;
            next_state      = IDLE;
          end else if (fcnt_inc == MAXLEN_L) begin
            push_entry.last  = 1'b1;
            push_entry.trunc = 1'b1;
            err_inc          = 1'b1;
            next_fcnt        = '0;
            next_state       = DROP;
          end else begin
            next_fcnt = fcnt_inc;
          end
        end
        DROP: begin
          if (flit_last) begin
            next_fcnt  = '0;
            next_state = IDLE;
          end
        end
        default: begin
          next_state = IDLE;
          next_fcnt  = '0;
        end
      endcase
    end
  end

  xskid2 #(
    .W (EW)
  ) u_skid (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (push_entry),
    .full  (skid_full),
    .valid (o_valid),
    .ready (o_ready),
    .dout  (head)
  );

  assign o_data  = head.data;
  assign o_last  = head.last;
  assign o_len   = head.len;
  assign o_trunc = head.trunc;

endmodule : xff_pkt_rd
`default_nettype wire
